mmio_arbiter: RTL and testbench

Two-requester arbiter that shares the single `mmio` port (UART control/data, counters, LEDs) between the CPU data path (requester 0) and a debug/bootloader master (requester 1). Each accepted request becomes exactly one `mmio_en` cycle, because an MMIO read of UART_RECEIVE_DATA pops the RX FIFO and must never be issued twice. The read result is registered and returned to the owning requester. The block sits between the CPU's memory-decode stage and `mmio`, and replaces the CPU's direct `en` drive.

---
 rtl/mmio_arbiter.sv | 148 ++++++++++++++
 tb/tb_mmio_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_arbiter.sv
// Two-requester arbiter for the shared mmio port: one mmio_en strobe per accepted request.
// Optional build macro MMIO_ARB_FIXED_PRIO_EN: requester 0 always wins contention (no round-robin pointer).
module mmio_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [3:0]            req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_din,
  output logic                  req0_ready,
  output logic                  req0_rvalid,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  input  logic                  req1_valid,
  input  logic [3:0]            req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_din,
  output logic                  req1_ready,
  output logic                  req1_rvalid,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  mmio_en,
  output logic [3:0]            mmio_we,
  output logic [ADDR_WIDTH-1:0] mmio_addr,
  output logic [DATA_WIDTH-1:0] mmio_din,
  input  logic [DATA_WIDTH-1:0] mmio_dout
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [3:0]            we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  grant0_s, grant1_s;
`ifndef MMIO_ARB_FIXED_PRIO_EN
  logic                  ptr_q, ptr_d;
`endif

  // Grant selection; gated by reset so ready stays low while reset is asserted.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if ((state_q == IDLE) && reset) begin
      if (req0_valid && req1_valid) begin
`ifdef MMIO_ARB_FIXED_PRIO_EN
        grant0_s = 1'b1;
`else
        grant0_s = ~ptr_q;
        grant1_s = ptr_q;
`endif
      end else begin
        grant0_s = req0_valid;
        grant1_s = req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Next-state and command/response capture.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
`ifndef MMIO_ARB_FIXED_PRIO_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant0_s || grant1_s) begin
          state_d = ISSUE;
          owner_d = grant1_s;
          we_d    = grant1_s ? req1_we   : req0_we;
          addr_d  = grant1_s ? req1_addr : req0_addr;
          din_d   = grant1_s ? req1_din  : req0_din;
`ifndef MMIO_ARB_FIXED_PRIO_EN
          // Prefer whichever requester just lost.
          ptr_d   = grant0_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d  = IDLE;
        rvalid_d = 1'b1;
        rdata_d  = (we_q == 4'b0000) ? mmio_dout : {DATA_WIDTH{1'b0}};
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 4'b0000;
      addr_q   <= {ADDR_WIDTH{1'b0}};
      din_q    <= {DATA_WIDTH{1'b0}};
      rdata_q  <= {DATA_WIDTH{1'b0}};
      rvalid_q <= 1'b0;
`ifndef MMIO_ARB_FIXED_PRIO_EN
      ptr_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
`ifndef MMIO_ARB_FIXED_PRIO_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign req0_ready  = grant0_s;
  assign req1_ready  = grant1_s;
  // owner_q only changes at the end of the response cycle, so it still names the responder here.
  assign req0_rvalid = rvalid_q & ~owner_q;
  assign req1_rvalid = rvalid_q &  owner_q;
  assign req0_rdata  = req0_rvalid ? rdata_q : {DATA_WIDTH{1'b0}};
  assign req1_rdata  = req1_rvalid ? rdata_q : {DATA_WIDTH{1'b0}};

  assign mmio_en   = (state_q == ISSUE);
  assign mmio_we   = mmio_en ? we_q : 4'b0000;
  assign mmio_addr = addr_q;
  assign mmio_din  = din_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed self-checking bench for mmio_arbiter with a command/response scoreboard.
// Honours MMIO_ARB_FIXED_PRIO_EN for the contention expectation.
module tb_mmio_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;

  typedef struct packed {
    logic [3:0]    we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } cmd_t;

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] data;
  } rsp_t;

  logic          clk, reset;
  logic          req0_valid, req1_valid;
  logic [3:0]    req0_we, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_din, req1_din;
  logic          req0_ready, req1_ready;
  logic          req0_rvalid, req1_rvalid;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic          mmio_en;
  logic [3:0]    mmio_we;
  logic [AW-1:0] mmio_addr;
  logic [DW-1:0] mmio_din;
  logic [DW-1:0] mmio_dout;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mmio_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_din(req0_din),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_din(req1_din),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mmio_en(mmio_en), .mmio_we(mmio_we), .mmio_addr(mmio_addr), .mmio_din(mmio_din),
    .mmio_dout(mmio_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [3:0] we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    cmd_t c;
    c.we = we; c.addr = addr; c.din = din;
    cmd_q.push_back(c);
  endtask

  task automatic push_rsp(input logic owner, input logic [DW-1:0] data);
    rsp_t r;
    r.owner = owner; r.data = data;
    rsp_q.push_back(r);
  endtask

  // Checks one cycle at the falling edge, then returns just after the next rising edge.
  task automatic step(input string tag, input logic e_r0, input logic e_r1, input logic e_en,
                      input logic e_v0, input logic e_v1);
    cmd_t c;
    rsp_t r;
    @(negedge clk);
    chk({tag, "/ready0"}, 64'(req0_ready), 64'(e_r0));
    chk({tag, "/ready1"}, 64'(req1_ready), 64'(e_r1));
    chk({tag, "/mmio_en"}, 64'(mmio_en), 64'(e_en));
    chk({tag, "/rvalid0"}, 64'(req0_rvalid), 64'(e_v0));
    chk({tag, "/rvalid1"}, 64'(req1_rvalid), 64'(e_v1));
    if (mmio_en) begin
      chk({tag, "/cmd_avail"}, 64'(cmd_q.size() != 0), 64'd1);
      if (cmd_q.size() != 0) begin
        c = cmd_q.pop_front();
        chk({tag, "/mmio_we"}, 64'(mmio_we), 64'(c.we));
        chk({tag, "/mmio_addr"}, 64'(mmio_addr), 64'(c.addr));
        chk({tag, "/mmio_din"}, 64'(mmio_din), 64'(c.din));
      end
    end else begin
      chk({tag, "/mmio_we_idle"}, 64'(mmio_we), 64'd0);
    end
    if (req0_rvalid || req1_rvalid) begin
      chk({tag, "/rsp_avail"}, 64'(rsp_q.size() != 0), 64'd1);
      if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        chk({tag, "/rsp_owner"}, 64'(req1_rvalid), 64'(r.owner));
        chk({tag, "/rsp_data"}, 64'(req1_rvalid ? req1_rdata : req0_rdata), 64'(r.data));
      end
    end
    if (!req0_rvalid) chk({tag, "/rdata0_idle"}, 64'(req0_rdata), 64'd0);
    if (!req1_rvalid) chk({tag, "/rdata1_idle"}, 64'(req1_rdata), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order[4];
    int prev;
`ifdef MMIO_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0};
`else
    order = '{0, 1, 0, 1};
`endif
    reset = 1'b0;
    req0_valid = 1'b1; req0_we = 4'b0000; req0_addr = 14'h0000; req0_din = 32'h0;
    req1_valid = 1'b1; req1_we = 4'b0000; req1_addr = 14'h0000; req1_din = 32'h0;
    mmio_dout = 32'h0;

    // Reset values with both requesters valid: no ready may escape.
    #3;
    chk("rst/ready0", 64'(req0_ready), 64'd0);
    chk("rst/ready1", 64'(req1_ready), 64'd0);
    chk("rst/mmio_en", 64'(mmio_en), 64'd0);
    chk("rst/mmio_we", 64'(mmio_we), 64'd0);
    chk("rst/mmio_addr", 64'(mmio_addr), 64'd0);
    chk("rst/mmio_din", 64'(mmio_din), 64'd0);
    chk("rst/rvalid", 64'({req0_rvalid, req1_rvalid}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;

    // Single read by req0.
    req0_valid = 1'b1; req0_we = 4'b0000; req0_addr = 14'h0010; req0_din = 32'h0;
    mmio_dout = 32'h0000_1234;
    push_cmd(4'b0000, 14'h0010, 32'h0);
    push_rsp(1'b0, 32'h0000_1234);
    step("rd_T", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    req0_valid = 1'b0;
    step("rd_T1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("rd_T2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Write by req1 gets a zero-data acknowledge.
    req1_valid = 1'b1; req1_we = 4'b0001; req1_addr = 14'h0030; req1_din = 32'h5;
    mmio_dout = 32'hDEAD_BEEF;
    push_cmd(4'b0001, 14'h0030, 32'h5);
    push_rsp(1'b1, 32'h0);
    step("wr_T", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    req1_valid = 1'b0;
    step("wr_T1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("wr_T2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Contention from a fresh reset.
    reset = 1'b0;
    step("cont_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    req0_valid = 1'b1; req0_we = 4'b0000; req0_addr = 14'h0100; req0_din = 32'h11;
    req1_valid = 1'b1; req1_we = 4'b1111; req1_addr = 14'h0200; req1_din = 32'h22;
    mmio_dout = 32'h77;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      if (order[k] == 0) begin
        push_cmd(4'b0000, 14'h0100, 32'h11);
        push_rsp(1'b0, 32'h77);
      end else begin
        push_cmd(4'b1111, 14'h0200, 32'h22);
        push_rsp(1'b1, 32'h0);
      end
      step($sformatf("cont%0d_grant", k), order[k] == 0, order[k] == 1, 1'b0, prev == 0, prev == 1);
      if (k == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      step($sformatf("cont%0d_issue", k), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      prev = order[k];
    end
    step("cont_last", 1'b0, 1'b0, 1'b0, prev == 0, prev == 1);

    // RX pop-once: valid held one cycle past ready.
    req0_valid = 1'b1; req0_we = 4'b0000; req0_addr = 14'h0004; req0_din = 32'h0;
    mmio_dout = 32'h0000_00A5;
    push_cmd(4'b0000, 14'h0004, 32'h0);
    push_rsp(1'b0, 32'h0000_00A5);
    step("rx_T", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rx_T1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    req0_valid = 1'b0;
    step("rx_T2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("rx_T3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // req1 raises valid during ISSUE and withdraws before it could be granted.
    req0_valid = 1'b1; req0_addr = 14'h0008; mmio_dout = 32'h0000_0042;
    push_cmd(4'b0000, 14'h0008, 32'h0);
    push_rsp(1'b0, 32'h0000_0042);
    step("wd_T", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b1; req1_we = 4'b0000; req1_addr = 14'h0040;
    step("wd_T1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    req1_valid = 1'b0;
    step("wd_T2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("wd_T3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during ISSUE; a req0 grant first leaves the round-robin pointer at 1.
    req0_valid = 1'b1; req0_addr = 14'h0020;
    step("ra_T", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ra/issue_en", 64'(mmio_en), 64'd1);
    #1;
    reset = 1'b0;
    req1_valid = 1'b1;
    #1;
    chk("ra/en_abort", 64'(mmio_en), 64'd0);
    chk("ra/we_abort", 64'(mmio_we), 64'd0);
    chk("ra/addr_rst", 64'(mmio_addr), 64'd0);
    chk("ra/ready_rst", 64'({req0_ready, req1_ready}), 64'd0);
    @(negedge clk);
    chk("ra/rvalid_rst", 64'({req0_rvalid, req1_rvalid}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    req0_addr = 14'h000C; mmio_dout = 32'h0000_0C0C;
    push_cmd(4'b0000, 14'h000C, 32'h0);
    push_rsp(1'b0, 32'h0000_0C0C);
    step("ra_post", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step("ra_post1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("ra_post2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("ra_post3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    chk("end/cmd_q_empty", 64'(cmd_q.size()), 64'd0);
    chk("end/rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
